// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard controller: pending-destination scoreboard, data/load-use stalls,
// forwarding selects and control-hazard handling. Optional macro: HAZARD_SCOREBOARD_FORWARD_EN.
module hazard_scoreboard #(
    parameter int NREG          = 32,
    parameter int AW            = 5,
    parameter int DEPTH         = 3,
    parameter int LOAD_STAGE    = 2,
    parameter int RESOLVE_STAGE = 2,
    parameter int PREDICT       = 0,
    parameter int CW            = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rs,
    input  logic [AW-1:0]                id_rt,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic                         id_wr,
    input  logic [AW-1:0]                id_rd,
    input  logic                         id_load,
    input  logic                         id_ctrl,
    input  logic                         redirect,
    output logic                         stall,
    output logic                         bubble,
    output logic                         fetch_nop,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
    output logic                         ctrl_pending,
    output logic [CW-1:0]                stall_cnt
);

    localparam int FW  = $clog2(DEPTH + 1);
    localparam int CTW = $clog2(RESOLVE_STAGE + 1);

    // Register 0 is hardwired zero, so it never produces or consumes a hazard.
    function automatic logic reg_live(input logic [AW-1:0] idx);
        return (idx != {AW{1'b0}}) && (32'(idx) < NREG);
    endfunction

    logic            v_r  [1:DEPTH];
    logic [AW-1:0]   rd_r [1:DEPTH];
    logic            ld_r [1:DEPTH];
    logic [CTW-1:0]  ctrl_cnt_r;
    logic [CTW-1:0]  ctrl_cnt_nxt_s;
    logic [CW-1:0]   stall_cnt_r;

    logic            use_a_s;
    logic            use_b_s;
    logic            hit_a_s;
    logic            hit_b_s;
    logic [FW-1:0]   k_a_s;
    logic [FW-1:0]   k_b_s;
    logic            ld_a_s;
    logic            ld_b_s;
    logic            lu_a_s;
    logic            lu_b_s;
    logic            data_stall_s;
    logic [FW-1:0]   fwd_a_s;
    logic [FW-1:0]   fwd_b_s;
    logic            flush_s;
    logic            stall_s;
    logic            pend_s;
    logic            fetch_nop_s;
    logic            load_s;
    logic            issue_s;
    logic            lost_s;

    assign use_a_s = id_valid & id_use_rs & reg_live(id_rs);
    assign use_b_s = id_valid & id_use_rt & reg_live(id_rt);

    // Youngest-match search per source: scan oldest to youngest so the lowest stage wins.
    always_comb begin
        hit_a_s = 1'b0;
        k_a_s   = {FW{1'b0}};
        ld_a_s  = 1'b0;
        hit_b_s = 1'b0;
        k_b_s   = {FW{1'b0}};
        ld_b_s  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            hit_a_s = hit_a_s | (use_a_s & v_r[k] & (rd_r[k] == id_rs));
            k_a_s   = (use_a_s & v_r[k] & (rd_r[k] == id_rs)) ? FW'(k) : k_a_s;
            ld_a_s  = (use_a_s & v_r[k] & (rd_r[k] == id_rs)) ? ld_r[k] : ld_a_s;
            hit_b_s = hit_b_s | (use_b_s & v_r[k] & (rd_r[k] == id_rt));
            k_b_s   = (use_b_s & v_r[k] & (rd_r[k] == id_rt)) ? FW'(k) : k_b_s;
            ld_b_s  = (use_b_s & v_r[k] & (rd_r[k] == id_rt)) ? ld_r[k] : ld_b_s;
        end
    end

    // Stall decision and forwarding selects for the configured forwarding mode.
    always_comb begin
        lu_a_s       = hit_a_s & ld_a_s & (32'(k_a_s) < LOAD_STAGE);
        lu_b_s       = hit_b_s & ld_b_s & (32'(k_b_s) < LOAD_STAGE);
        data_stall_s = 1'b0;
        fwd_a_s      = {FW{1'b0}};
        fwd_b_s      = {FW{1'b0}};
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        data_stall_s = lu_a_s | lu_b_s;
        if (hit_a_s && !lu_a_s) begin
            fwd_a_s = k_a_s;
        end else begin
            fwd_a_s = {FW{1'b0}};
        end
        if (hit_b_s && !lu_b_s) begin
            fwd_b_s = k_b_s;
        end else begin
            fwd_b_s = {FW{1'b0}};
        end
`else
        // Without bypass paths, any pending producer blocks ID until it retires.
        data_stall_s = hit_a_s | hit_b_s | lu_a_s | lu_b_s;
`endif
    end

    assign flush_s     = (PREDICT != 0) & redirect & rst_n;
    assign stall_s     = data_stall_s & ~flush_s;
    assign pend_s      = (ctrl_cnt_r != {CTW{1'b0}});
    assign fetch_nop_s = (PREDICT == 0) & pend_s;
    assign load_s      = id_valid & id_wr & reg_live(id_rd) & ~stall_s & ~flush_s;
    assign issue_s     = id_valid & id_ctrl & ~stall_s & ~flush_s;
    assign lost_s      = stall_s | fetch_nop_s | flush_s;

    // Scoreboard shift; a flush kills the entries younger than the resolving branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                v_r[k]  <= 1'b0;
                rd_r[k] <= {AW{1'b0}};
                ld_r[k] <= 1'b0;
            end
        end else begin
            v_r[1]  <= load_s;
            rd_r[1] <= id_rd;
            ld_r[1] <= id_load;
            for (int k = 1; k < DEPTH; k++) begin
                v_r[k+1]  <= v_r[k] & ~(flush_s & (k < RESOLVE_STAGE));
                rd_r[k+1] <= rd_r[k];
                ld_r[k+1] <= ld_r[k];
            end
        end
    end

    // Control-transfer countdown: loaded at issue, cleared early by a redirect.
    always_comb begin
        ctrl_cnt_nxt_s = ctrl_cnt_r;
        if (redirect) begin
            ctrl_cnt_nxt_s = {CTW{1'b0}};
        end else if (issue_s) begin
            ctrl_cnt_nxt_s = CTW'(RESOLVE_STAGE);
        end else if (pend_s) begin
            ctrl_cnt_nxt_s = ctrl_cnt_r - CTW'(1'b1);
        end else begin
            ctrl_cnt_nxt_s = ctrl_cnt_r;
        end
    end

    // Control counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cnt_r <= {CTW{1'b0}};
        end else begin
            ctrl_cnt_r <= ctrl_cnt_nxt_s;
        end
    end

    // Saturating lost-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (lost_s && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CW'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall        = stall_s;
    assign bubble       = stall_s;
    assign fetch_nop    = fetch_nop_s;
    assign flush        = flush_s;
    assign fwd_a        = fwd_a_s;
    assign fwd_b        = fwd_b_s;
    assign ctrl_pending = pend_s;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard controller for the in-order pipeline. It tracks pending destination registers across the stages between ID and register-file write-back, and decides data stalls, load-use stalls and forwarding selects. It also handles control hazards, either by fetch-hold or by predict-not-taken with flush. It sits beside the ID stage and drives PC/IF-ID hold, ID/EX bubble, IF/ID flush and the EX operand muxes.

## Interface
Parameters:
- NREG, 32, architectural register count; register 0 is hardwired zero and never hazards.
- AW, 5, register index width; must satisfy 2^AW >= NREG.
- DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB).
- LOAD_STAGE, 2, first stage whose output carries load data.
- RESOLVE_STAGE, 2, stage in which branch/jump resolves and `redirect` is raised.
- PREDICT, 0, 0 = hold fetch until resolution; 1 = predict not-taken, flush on redirect.
- CW, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source register indices.
- id_use_rs, id_use_rt  in  1  corresponding source is actually read.
- id_wr  in  1  ID instruction writes a register.
- id_rd  in  AW  destination index.
- id_load  in  1  ID instruction is a load.
- id_ctrl  in  1  ID instruction is a branch/jump.
- redirect  in  1  taken branch/jump resolved at RESOLVE_STAGE this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load nop into ID/EX.
- fetch_nop  out  1  load nop into IF/ID (PREDICT=0 hold).
- flush  out  1  invalidate IF/ID and ID/EX (PREDICT=1).
- fwd_a, fwd_b  out  $clog2(DEPTH+1)  operand source: 0 = regfile, k = stage-k result.
- ctrl_pending  out  1  unresolved control transfer in flight.
- stall_cnt  out  CW  saturating count of lost cycles.

## Operation
- Scoreboard: DEPTH entries {v, rd, ld}. Entry k is the instruction in stage k.
- Every cycle, entries shift k→k+1 and entry DEPTH retires.
- Entry 1 loads the ID instruction when id_valid & id_wr & rd≠0 & ~stall & ~flush. Otherwise entry 1 loads v=0.
- Match on a source: used & index≠0 & entry valid & entry.rd == index. The youngest matching stage (lowest k) wins.
- With FORWARD_EN:
  - Stall if the youngest match has ld=1 and k < LOAD_STAGE.
  - Otherwise fwd = k of the youngest match, or 0 if no match.
- Without FORWARD_EN: stall on any match in stages 1..DEPTH; fwd_a and fwd_b are held at 0.
- bubble = stall.
- Control, PREDICT=0:
  - When a control instruction leaves ID (id_valid & id_ctrl & ~stall), ctrl_cnt loads RESOLVE_STAGE.
  - While ctrl_cnt≠0: fetch_nop=1 and ctrl_pending=1; ctrl_cnt decrements each cycle.
  - redirect forces ctrl_cnt to 0.
- Control, PREDICT=1:
  - fetch_nop=0.
  - redirect sets flush=1 for that cycle.
  - Flush invalidates scoreboard entries 1..RESOLVE_STAGE-1 and blocks the ID load into entry 1.
  - ctrl_pending is high from issue until redirect, or until RESOLVE_STAGE cycles have elapsed.
- Priorities:
  - flush overrides stall: stall=bubble=0 in a flush cycle.
  - stall blocks a control instruction from issuing.
  - A data stall and fetch_nop may coexist.
- stall_cnt increments on any cycle with stall|fetch_nop|flush and saturates at 2^CW−1.

## Timing
- stall, bubble, fwd_a/b and flush are combinational from the current ID inputs, registered state and redirect, in the same cycle.
- Scoreboard, ctrl_cnt and stall_cnt update on the rising clk edge.
- Load-use penalty: LOAD_STAGE−1 cycles with FORWARD_EN. RAW penalty without forwarding: up to DEPTH cycles.
- Control penalty: RESOLVE_STAGE cycles (PREDICT=0), or RESOLVE_STAGE cycles on taken only (PREDICT=1).
- Reset: all entries v=0 and ctrl_cnt=0. All outputs are 0; stall_cnt=0.
- Reset mid-stall releases stall asynchronously.

## Configuration
- HAZARD_SCOREBOARD_FORWARD_EN defined: forwarding is enabled; only load-use stalls.
- Not defined: no forwarding; any RAW on a pending register stalls until retirement; fwd outputs are constant 0.

## Test plan
- add r3 then add r4←r3 (FORWARD_EN): stall=0, fwd_a=1. Without the macro: stall for 3 cycles, then fwd_a=0.
- lw r5 then add using r5 as rt (FORWARD_EN, LOAD_STAGE=2): exactly 1 cycle of stall/bubble, then fwd_b=2.
- ID reads r0 while entry 1 writes r0 (id_wr=1, rd=0): no stall, fwd=0.
- PREDICT=0 beq: fetch_nop high for 2 cycles, ctrl_pending mirrors it, stall_cnt increases by 2.
- PREDICT=1: redirect asserted at the same cycle as a load-use stall → flush=1, stall=0, entry 1 invalid next cycle.
- Drive 70000 stall cycles with CW=16 → stall_cnt saturates at 65535. Assert rst_n=0 mid-stall → all outputs 0 immediately.
